// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage for an RV32 core.
// Keeps the PC and issues one read per cycle to a synchronous instruction
// memory that answers one cycle later. The returned word and its PC are
// registered into the IF/ID register. When the stage is stalled, a response
// that is already in flight is parked in a one-entry skid buffer. A redirect
// restarts fetching at a new target and takes priority over a stall.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // Fetch PCs are word aligned. Bits [1:0] of RESET_PC are forced to zero,
  // so a misconfigured parameter cannot produce an unaligned fetch.
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic [31:0] pc;             // address of the next request
  logic        resp_pending;   // imem_rdata carries a response this cycle
  logic [31:0] resp_pc;        // PC of the response in flight
  logic        hold_valid;     // skid buffer occupied
  fetch_t      hold;           // skid buffer contents
  fetch_t      resp;           // response currently on the memory bus
  logic [31:0] redirect_target;

  // Bits [1:0] of the redirect target are dropped on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign resp            = '{pc: resp_pc, instr: imem_rdata};

  // A request goes out whenever the stage is free to advance. A stall blocks
  // the request, so at most one response is in flight while the stage waits.
  // This is why a single skid entry is enough.
  assign imem_req  = !reset && !stall && !redirect_valid;
  assign imem_addr = pc;

  // PC and request tracking: advance on each issued request, jump on redirect.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments on every register, so all of them take
    // the values from before the edge regardless of statement order.
    if (reset) begin
      pc           <= START_PC;
      resp_pending <= 1'b0;
    end else if (imem_req) begin
      pc           <= pc + 32'd4;  // 32'hFFFF_FFFC wraps to 0
      resp_pending <= 1'b1;
    end else begin
      resp_pending <= 1'b0;
      if (redirect_valid) begin
        pc <= redirect_target;
      end
    end
  end

  // PC of the word in flight. This is a data-only register, so it has no reset.
  always_ff @(posedge clk) begin
    // NOTE: data registers like this one are left unreset on purpose. The
    // matching valid flag (here resp_pending) is what resets and qualifies
    // them, which keeps the reset net off the wide datapath.
    if (imem_req) begin
      resp_pc <= pc;
    end
  end

  // Skid buffer data: capture a response that arrives while stalled.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && stall && resp_pending) begin
      hold <= resp;
    end
  end

  // Skid occupancy and the IF/ID register, in priority order:
  // reset, then redirect, then stall, then normal advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid      <= 1'b0;
      out_valid       <= 1'b0;
      out_pc          <= 32'h0000_0000;
      out_instruction <= NOP_INSTR;
    end else if (redirect_valid) begin
      // Wrong-path work is squashed. out_pc and out_instruction keep their
      // values, and out_valid marks them as stale.
      hold_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else if (stall) begin
      // IF/ID holds. A response landing now is parked in the skid buffer.
      if (resp_pending) begin
        hold_valid <= 1'b1;
      end
    end else if (hold_valid) begin
      hold_valid      <= 1'b0;
      out_valid       <= 1'b1;
      out_pc          <= hold.pc;
      out_instruction <= hold.instr;
    end else if (resp_pending) begin
      out_valid       <= 1'b1;
      out_pc          <= resp.pc;
      out_instruction <= resp.instr;
    end else begin
      out_valid <= 1'b0;  // bubble
    end
  end

endmodule
